// File: rtl/sram_boot_loader.sv
// Boot loader for one sram_32_1024_freepdk45 macro. Streams 32-bit words
// into the macro from address 0 while the core is held in reset, then
// permanently hands the macro port to ssram_wrap until the next RSTn.
module sram_boot_loader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              start_i,
  input  logic [ADDR_W:0]   len_i,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              wrap_csb,
  input  logic              wrap_web,
  input  logic [ADDR_W-1:0] wrap_addr,
  input  logic [DATA_W-1:0] wrap_din,
  output logic              mem_csb,
  output logic              mem_web,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              core_RSTn,
  output logic              load_busy,
  output logic              load_done,
  output logic [ADDR_W:0]   word_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  // Requests longer than the macro are cut to DEPTH so the address never wraps.
  function automatic logic [ADDR_W:0] clamp_len(input logic [ADDR_W:0] l);
    return (l > DEPTH_W) ? DEPTH_W : l;
  endfunction

  logic [1:0]        state;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   cnt_q;
  logic              pass_q;
  logic              handshake;
  logic              last_word;

  // Stage p1: registered write port presented to the macro one cycle after
  // the stream handshake.
  logic              wr_csb_p1;
  logic              wr_web_p1;
  logic [ADDR_W-1:0] wr_addr_p1;
  logic [DATA_W-1:0] wr_din_p1;

  assign handshake = in_valid && (state == S_LOAD);
  assign last_word = (cnt_q == (len_q - 1'b1));

  // Load sequencing, write-port register and the hand-over flag.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state      <= S_IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      pass_q     <= 1'b0;
      wr_csb_p1  <= 1'b1;
      wr_web_p1  <= 1'b1;
      wr_addr_p1 <= '0;
      wr_din_p1  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          wr_csb_p1 <= 1'b1;
          wr_web_p1 <= 1'b1;
          if (start_i) begin
            if (len_i == '0) begin
              state  <= S_DONE;
              pass_q <= 1'b1;
            end else begin
              state <= S_LOAD;
              len_q <= clamp_len(len_i);
              cnt_q <= '0;
            end
          end
        end
        S_LOAD: begin
          if (handshake) begin
            wr_csb_p1  <= 1'b0;
            wr_web_p1  <= 1'b0;
            wr_addr_p1 <= cnt_q[ADDR_W-1:0];
            wr_din_p1  <= in_data;
            cnt_q      <= cnt_q + 1'b1;
            if (last_word) state <= S_FLUSH;
          end else begin
            wr_csb_p1 <= 1'b1;
            wr_web_p1 <= 1'b1;
          end
        end
        S_FLUSH: begin
          // The last write is on the port during this cycle; close it now.
          wr_csb_p1 <= 1'b1;
          wr_web_p1 <= 1'b1;
          state     <= S_DONE;
          pass_q    <= 1'b1;
        end
        default: begin
          state <= S_DONE;
        end
      endcase
    end
  end

  // Port mux: the select is a dedicated flop so the hand-over cannot glitch.
  always_comb begin
    mem_csb  = pass_q ? wrap_csb  : wr_csb_p1;
    mem_web  = pass_q ? wrap_web  : wr_web_p1;
    mem_addr = pass_q ? wrap_addr : wr_addr_p1;
    mem_din  = pass_q ? wrap_din  : wr_din_p1;
  end

  assign in_ready  = (state == S_LOAD);
  assign load_busy = (state == S_LOAD) || (state == S_FLUSH);
  assign load_done = pass_q;
  assign core_RSTn = pass_q;
  assign word_cnt  = cnt_q;

endmodule

// File: doc/sram_boot_loader.md
Name: sram_boot_loader

Overview:
- Synthesizable replacement for the bench-side memory flashing. Accepts a 32-bit word stream (valid/ready) and writes it sequentially from address 0 into one sram_32_1024_freepdk45 macro.
- Sits between the ssram_wrap SRAM-side signals and the macro port, muxing the two.
- Holds the core in reset until loading completes, then hands the port to ssram_wrap permanently (until the next RSTn).
- One instance per memory (instruction and data).

Parameters:
- ADDR_W, 10, SRAM address width.
- DATA_W, 32, SRAM word width.
- DEPTH, 1024, SRAM depth in words; must equal 2**ADDR_W.

Ports:
- CLK  in  1  system clock, all state on rising edge.
- RSTn  in  1  asynchronous active-low reset.
- start_i  in  1  one-cycle pulse; begins a load of len_i words; sampled only in IDLE.
- len_i  in  ADDR_W+1  number of words to load, 0..DEPTH; sampled with start_i.
- in_valid  in  1  stream word valid.
- in_data  in  DATA_W  stream word.
- in_ready  out  1  loader accepts the word this cycle.
- wrap_csb  in  1  chip select (active low) from ssram_wrap.
- wrap_web  in  1  write enable (active low) from ssram_wrap.
- wrap_addr  in  ADDR_W  address from ssram_wrap.
- wrap_din  in  DATA_W  write data from ssram_wrap.
- mem_csb  out  1  to macro csb0.
- mem_web  out  1  to macro web0.
- mem_addr  out  ADDR_W  to macro addr0.
- mem_din  out  DATA_W  to macro din0.
- core_RSTn  out  1  active-low reset to riscv_core / ssram_wrap.
- load_busy  out  1  high in LOAD or FLUSH.
- load_done  out  1  high in DONE.
- word_cnt  out  ADDR_W+1  words accepted in the current load.

Behaviour:
- Reset (async, RSTn=0):
  - state=IDLE, in_ready=0, word_cnt=0, core_RSTn=0, load_busy=0, load_done=0.
  - Registered write port: csb=1, web=1, addr=0, din=0. mem_* reflect these values.
  - An RSTn assertion mid-load aborts the load; no partial-write completion is guaranteed.
- States:
  - IDLE: mem_* driven from the idle registers (csb=1, web=1). in_ready=0.
    - start_i with len_i=0: go to DONE.
    - start_i otherwise: go to LOAD. Latch len=min(len_i,DEPTH); word_cnt<=0.
  - LOAD: in_ready=1.
    - Handshake (in_valid&in_ready) while word_cnt=k: next cycle mem_csb=0, mem_web=0, mem_addr=k, mem_din=captured in_data; word_cnt<=k+1.
    - No handshake: next cycle mem_csb=1, mem_web=1 (no write).
    - Handshake with k=len-1: go to FLUSH.
    - start_i is ignored.
  - FLUSH: one cycle. The final registered write is presented to the macro. in_ready=0. Then go to DONE.
  - DONE: terminal until RSTn.
    - mem_*=wrap_* combinationally (pass-through).
    - core_RSTn=1 from the first DONE cycle; it is a register set on the transition into DONE.
    - load_done=1, in_ready=0. start_i is ignored.
- Write latency: 1 cycle from stream handshake to the write presented at the macro. The macro captures the write on the following edge.
- Throughput: one word per cycle. Back-to-back handshakes produce consecutive addresses with no bubbles.
- In LOAD/FLUSH, wrap_* are ignored. The core is held in reset throughout, so no core traffic occurs.
- Address wraps never occur: len is clamped to DEPTH, so the maximum address is DEPTH-1.
- Clamping: len_i>DEPTH loads DEPTH words; word_cnt saturates at DEPTH.
- mem_* in IDLE/LOAD/FLUSH are glitch-free register outputs. In DONE the mux select is a registered state bit.

Test Plan:
- Reset, then start_i with len_i=12, stream 0x00000013..0x0000001E with in_valid held high:
  - Writes appear at addr 0..11 on 12 consecutive cycles.
  - FLUSH follows, then DONE; core_RSTn rises 14 cycles after start_i.
  - Reading back through the ssram_wrap pass-through returns the same 12 words.
- len_i=4 with in_valid toggling 1,0,1,0,...:
  - mem_csb is low only on cycles after a handshake.
  - Addresses are 0,1,2,3 with no skipped or duplicated writes; word_cnt ends at 4.
- len_i=0:
  - Next cycle is DONE with core_RSTn=1.
  - mem_csb stays 1 until wrap_csb drives it.
  - No in_ready pulse occurs.
- len_i=1500:
  - Exactly 1024 writes, last at addr 1023.
  - in_ready drops after word 1024; word_cnt=1024.
- Assert RSTn=0 after 5 of 12 words:
  - All outputs return to reset values asynchronously; core_RSTn=0.
  - A fresh start_i with len_i=3 rewrites addr 0..2.
- In DONE, drive wrap_csb=0, wrap_web=0, wrap_addr=0x3FF, wrap_din=0xDEADBEEF:
  - mem_* mirror these values the same cycle.
  - A start_i and in_valid pulse has no effect.
